// File: rtl/idli_sqi_arb_m.sv
// idli_sqi_arb_m: arbitrates the SQI controller between instruction fetch (F)
// and load/store (D). One transaction at a time. D has priority, and a
// starvation counter forces an F grant after STARVE_MAX consecutive D grants.
// A chip-select turnaround gap separates transactions.
module idli_sqi_arb_m #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TURN_CYC   = 1
) (
    input  logic              i_arb_gck,
    input  logic              i_arb_rst_n,
    input  logic              i_arb_f_req,
    input  logic [ADDR_W-1:0] i_arb_f_addr,
    output logic              o_arb_f_ack,
    input  logic              i_arb_d_req,
    input  logic              i_arb_d_wr,
    input  logic [ADDR_W-1:0] i_arb_d_addr,
    output logic              o_arb_d_ack,
    output logic              o_arb_sqi_req,
    output logic              o_arb_sqi_wr,
    output logic [ADDR_W-1:0] o_arb_sqi_addr,
    input  logic              i_arb_sqi_done,
    output logic              o_arb_busy
);

    localparam int unsigned          STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0]  STARVE_TOP = STARVE_W'(STARVE_MAX);
    localparam logic [2:0]           TURN_LOAD  = (TURN_CYC == 0) ? 3'd0 : 3'(TURN_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_F = 2'd1,
        GNT_D = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [STARVE_W-1:0] starve_cnt;
    logic [2:0]          turn_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;
    logic                grant_f;
    logic                grant_d;
    logic                f_forced;
    logic                txn_end;

    // Next-state decode, grant selection and combinational acks.
    always_comb begin
        state_d     = state_q;
        grant_f     = 1'b0;
        grant_d     = 1'b0;
        f_forced    = i_arb_f_req && (starve_cnt == STARVE_TOP);
        txn_end     = 1'b0;
        o_arb_f_ack = 1'b0;
        o_arb_d_ack = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_arb_d_req && !f_forced) begin
                    state_d = GNT_D;
                    grant_d = 1'b1;
                end else if (i_arb_f_req) begin
                    state_d = GNT_F;
                    grant_f = 1'b1;
                end
            end
            GNT_F, GNT_D: begin
                if (i_arb_sqi_done) begin
                    txn_end     = 1'b1;
                    o_arb_f_ack = (state_q == GNT_F);
                    o_arb_d_ack = (state_q == GNT_D);
                    state_d     = (TURN_CYC == 0) ? IDLE : TURN;
                end
            end
            TURN: begin
                if (turn_cnt == 3'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, turnaround counter, starvation counter and latched transaction.
    always_ff @(posedge i_arb_gck or negedge i_arb_rst_n) begin
        if (!i_arb_rst_n) begin
            state_q    <= IDLE;
            starve_cnt <= '0;
            turn_cnt   <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
        end else begin
            state_q <= state_d;

            if (txn_end) begin
                turn_cnt <= TURN_LOAD;
            end else if (state_q == TURN && turn_cnt != 3'd0) begin
                turn_cnt <= turn_cnt - 3'd1;
            end

            if (grant_d) begin
                addr_q <= i_arb_d_addr;
                wr_q   <= i_arb_d_wr;
            end else if (grant_f) begin
                addr_q <= i_arb_f_addr;
                wr_q   <= 1'b0;
            end

            // An F grant or an idle cycle with no F pending both end starvation.
            if (grant_f || (state_q == IDLE && !i_arb_f_req)) begin
                starve_cnt <= '0;
            end else if (grant_d && starve_cnt != STARVE_TOP) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign o_arb_sqi_req  = (state_q == GNT_F) || (state_q == GNT_D);
    assign o_arb_sqi_wr   = wr_q;
    assign o_arb_sqi_addr = addr_q;
    assign o_arb_busy     = (state_q != IDLE);

endmodule
